regfile_wb_arb: RTL and testbench

//   Writeback arbiter and queue that drives the register file write port (we/waddr/wdata).

---
 rtl/regfile_wb_arb.sv | 115 +++++++++++
 tb/tb_regfile_wb_arb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arb.sv
// Writeback arbiter for the register file write port.
// Load and ALU results are queued in a small circular FIFO and retired one
// per cycle. A mask of queued destinations is exported for issue stalls.
module regfile_wb_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        alu_valid_i,
    output logic                        alu_ready_o,
    input  logic [ADDR_W-1:0]           alu_rd_i,
    input  logic [DATA_W-1:0]           alu_data_i,
    input  logic                        ld_valid_i,
    output logic                        ld_ready_o,
    input  logic [ADDR_W-1:0]           ld_rd_i,
    input  logic [DATA_W-1:0]           ld_data_i,
    output logic                        we_o,
    output logic [ADDR_W-1:0]           waddr_o,
    output logic [DATA_W-1:0]           wdata_o,
    output logic [(1<<ADDR_W)-1:0]      pend_mask_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] rd_mem_q   [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [CNT_W-1:0]  free;
    logic              ld_rdy, alu_rdy;
    logic              ld_push, alu_push, pop;
    logic [PTR_W-1:0]  alu_slot;

    // Readiness from occupancy at the start of the cycle; the pop in flight
    // is deliberately not credited so both pushes always find room.
    always_comb begin
        free     = CNT_W'(FIFO_DEPTH) - count_q;
        ld_rdy   = (free != '0);
        alu_rdy  = (free >= CNT_W'(2)) | ((free != '0) & ~ld_valid_i);
        ld_push  = ld_valid_i & ld_rdy & (ld_rd_i != '0);
        alu_push = alu_valid_i & alu_rdy & (alu_rd_i != '0);
        pop      = (count_q != '0);
        alu_slot = wr_ptr_q + PTR_W'(ld_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(ld_push) + PTR_W'(alu_push);
        count_d  = count_q + CNT_W'(ld_push) + CNT_W'(alu_push) - CNT_W'(pop);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; the load is older, so it takes the first free slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            if (ld_push) begin
                rd_mem_q[wr_ptr_q]   <= ld_rd_i;
                data_mem_q[wr_ptr_q] <= ld_data_i;
            end
            if (alu_push) begin
                rd_mem_q[alu_slot]   <= alu_rd_i;
                data_mem_q[alu_slot] <= alu_data_i;
            end
        end
    end

    // Pending mask: OR of one-hot destinations over occupied entries only.
    always_comb begin
        logic [PTR_W-1:0] off;
        pend_mask_o = '0;
        off         = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(off) < count_q) begin
                pend_mask_o[rd_mem_q[i]] = 1'b1;
            end
        end
        pend_mask_o[0] = 1'b0;
    end

    // Commit port from queue registers only; readies are forced low in reset.
    always_comb begin
        we_o         = pop;
        waddr_o      = pop ? rd_mem_q[rd_ptr_q]   : '0;
        wdata_o      = pop ? data_mem_q[rd_ptr_q] : '0;
        fifo_count_o = count_q;
        ld_ready_o   = rst_ni & ld_rdy;
        alu_ready_o  = rst_ni & alu_rdy;
    end

    logic unused_ok;
    assign unused_ok = (NREG > 0);

endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomised and directed bench for the writeback arbiter, checked against a
// queue-based model of the pending writes.
module tb_regfile_wb_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready, we;
    logic [4:0]  alu_rd, ld_rd, waddr;
    logic [31:0] alu_data, ld_data, wdata, pend_mask;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    regfile_wb_arb #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_rd_i(ld_rd), .ld_data_i(ld_data),
        .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .pend_mask_o(pend_mask), .fifo_count_o(fifo_count)
    );

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // One cycle: apply inputs at negedge, sample readies, advance the model at
    // posedge, return at the following negedge.
    task automatic drive(input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                         input bit av, input logic [4:0] ard, input logic [31:0] adat,
                         output bit ldr_obs, output bit alr_obs,
                         output bit ldr_exp, output bit alr_exp);
        int   free;
        ent_t e;
        ld_valid = lv; ld_rd = lrd; ld_data = ldat;
        alu_valid = av; alu_rd = ard; alu_data = adat;
        #1;
        free    = 4 - mq.size();
        ldr_exp = (free >= 1);
        alr_exp = (free >= 2) || ((free >= 1) && !lv);
        ldr_obs = ld_ready;
        alr_obs = alu_ready;
        @(posedge clk);
        if (mq.size() > 0) void'(mq.pop_front());
        if (lv && ldr_exp && lrd != 0) begin e.rd = lrd; e.d = ldat; mq.push_back(e); end
        if (av && alr_exp && ard != 0) begin e.rd = ard; e.d = adat; mq.push_back(e); end
        @(negedge clk);
        ld_valid = 1'b0; alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ld_valid = 0; alu_valid = 0; ld_rd = 0; alu_rd = 0; ld_data = 0; alu_data = 0;
        repeat (2) @(negedge clk);
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_checks++; if (pend_mask !== 32'd0) begin n_fail++; $display("FAIL reset_pend got %h want 0", pend_mask); end
        n_checks++; if ({ld_ready, alu_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {ld_ready, alu_ready}); end
        n_checks++; if ({waddr, wdata} !== 37'd0) begin n_fail++; $display("FAIL reset_wport got %h/%h want 0", waddr, wdata); end
        rst_n = 1'b1;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_single();
        bit lo, ao, le, ae;
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, lo, ao, le, ae);
        n_checks++; if (ao !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", ao); end
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            begin n_fail++; $display("FAIL single_commit got %b/%0d/%h want 1/5/deadbeef", we, waddr, wdata); end
        n_checks++; if (pend_mask !== 32'h20) begin n_fail++; $display("FAIL single_pend got %h want 20", pend_mask); end
        drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
        n_checks++; if ({we, pend_mask} !== 33'd0) begin n_fail++; $display("FAIL single_idle got we=%b pend=%h want 0", we, pend_mask); end
    endtask

    task automatic test_same_cycle();
        bit lo, ao, le, ae;
        drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, lo, ao, le, ae);
        n_checks++; if ({lo, ao} !== 2'b11) begin n_fail++; $display("FAIL same_ready got %b want 11", {lo, ao}); end
        n_checks++; if ({fifo_count, waddr, wdata} !== {3'd2, 5'd3, 32'h11})
            begin n_fail++; $display("FAIL same_first got cnt=%0d %0d<=%h want 2 3<=11", fifo_count, waddr, wdata); end
        drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
        n_checks++; if ({fifo_count, we, waddr, wdata} !== {3'd1, 1'b1, 5'd3, 32'h22})
            begin n_fail++; $display("FAIL same_second got cnt=%0d %0d<=%h want 1 3<=22", fifo_count, waddr, wdata); end
        drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
        n_checks++; if ({fifo_count, we} !== 4'd0) begin n_fail++; $display("FAIL same_drain got cnt=%0d we=%b want 0", fifo_count, we); end
    endtask

    task automatic test_fill();
        bit lo, ao, le, ae;
        bit saw_alu_stall = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 5'(2*k+1), $urandom, 1, 5'(2*k+2), $urandom, lo, ao, le, ae);
            if (!ae) saw_alu_stall = 1;
            n_checks++; if ({lo, ao} !== {le, ae}) begin n_fail++; $display("FAIL fill_ready k=%0d got %b want %b", k, {lo, ao}, {le, ae}); end
            n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL fill_count k=%0d got %0d want %0d", k, fifo_count, mq.size()); end
            n_checks++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL fill_pend k=%0d got %h want %h", k, pend_mask, model_mask()); end
            n_checks++; if ({waddr, wdata} !== {mq[0].rd, mq[0].d}) begin n_fail++; $display("FAIL fill_head k=%0d got %0d<=%h want %0d<=%h", k, waddr, wdata, mq[0].rd, mq[0].d); end
        end
        n_checks++; if (!saw_alu_stall) begin n_fail++; $display("FAIL fill_alu_stall got none want at least one"); end
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            n_checks++; if ({we, waddr, wdata} !== {1'b1, mq[0].rd, mq[0].d})
                begin n_fail++; $display("FAIL drain_head got %b %0d<=%h want 1 %0d<=%h", we, waddr, wdata, mq[0].rd, mq[0].d); end
            drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
        end
        n_checks++; if ({we, fifo_count} !== 4'd0) begin n_fail++; $display("FAIL drain_empty got we=%b cnt=%0d want 0", we, fifo_count); end
    endtask

    task automatic test_rd_zero();
        bit lo, ao, le, ae;
        drive(0, 0, 0, 1, 5'd0, 32'hFFFFFFFF, lo, ao, le, ae);
        n_checks++; if (ao !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b want 1", ao); end
        n_checks++; if ({we, fifo_count, pend_mask} !== 36'd0)
            begin n_fail++; $display("FAIL rd0_effect got we=%b cnt=%0d pend=%h want 0", we, fifo_count, pend_mask); end
    endtask

    task automatic test_back_to_back();
        bit lo, ao, le, ae;
        for (int i = 1; i <= 10; i++) begin
            drive(0, 0, 0, 1, 5'(i), 32'(i * 32'h100), lo, ao, le, ae);
            n_checks++; if ({we, waddr, wdata, fifo_count} !== {1'b1, 5'(i), 32'(i * 32'h100), 3'd1})
                begin n_fail++; $display("FAIL b2b_%0d got %b %0d<=%h cnt=%0d want 1 %0d<=%h cnt=1", i, we, waddr, wdata, fifo_count, i, i * 256); end
        end
        drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL b2b_end got we=%b want 0", we); end
    endtask

    task automatic test_reset_mid();
        bit lo, ao, le, ae;
        drive(1, 5'd7, 32'h70, 1, 5'd8, 32'h80, lo, ao, le, ae);
        drive(1, 5'd9, 32'h90, 1, 5'd10, 32'hA0, lo, ao, le, ae);
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_pre_count got %0d want 3", fifo_count); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({we, fifo_count, pend_mask, ld_ready, alu_ready} !== 38'd0)
            begin n_fail++; $display("FAIL mid_async got we=%b cnt=%0d pend=%h rdy=%b%b want 0", we, fifo_count, pend_mask, ld_ready, alu_ready); end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 0, 0, 1, 5'd12, 32'hC0FFEE, lo, ao, le, ae);
        n_checks++; if ({we, waddr, wdata, pend_mask} !== {1'b1, 5'd12, 32'hC0FFEE, 32'h1000})
            begin n_fail++; $display("FAIL mid_after got %b %0d<=%h pend=%h want 1 12<=c0ffee pend=1000", we, waddr, wdata, pend_mask); end
        drive(0, 0, 0, 0, 0, 0, lo, ao, le, ae);
    endtask

    task automatic test_random();
        bit lo, ao, le, ae;
        for (int k = 0; k < 300; k++) begin
            drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom, lo, ao, le, ae);
            n_checks++; if ({lo, ao} !== {le, ae}) begin n_fail++; $display("FAIL rnd_ready k=%0d got %b want %b", k, {lo, ao}, {le, ae}); end
            n_checks++; if (fifo_count !== 3'(mq.size())) begin n_fail++; $display("FAIL rnd_count k=%0d got %0d want %0d", k, fifo_count, mq.size()); end
            n_checks++; if (pend_mask !== model_mask()) begin n_fail++; $display("FAIL rnd_pend k=%0d got %h want %h", k, pend_mask, model_mask()); end
            if (mq.size() > 0) begin
                n_checks++; if ({we, waddr, wdata} !== {1'b1, mq[0].rd, mq[0].d})
                    begin n_fail++; $display("FAIL rnd_head k=%0d got %b %0d<=%h want 1 %0d<=%h", k, we, waddr, wdata, mq[0].rd, mq[0].d); end
            end else begin
                n_checks++; if ({we, waddr, wdata} !== 38'd0)
                    begin n_fail++; $display("FAIL rnd_empty k=%0d got %b %0d<=%h want 0", k, we, waddr, wdata); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        test_fill();
        test_rd_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
